// File: rtl/scoreboard_ctrl_pkg.sv
// Shared definitions for the PRV664 integer-register scoreboard.
// Provides the itag width, the architectural register count and the
// record types used for scoreboard entries and writeback clear requests.
package scoreboard_ctrl_pkg;

  localparam int SB_TAGW  = 8;
  localparam int SB_NREGS = 32;

  typedef struct packed {
    logic               busy;
    logic [SB_TAGW-1:0] itag;
  } sb_entry_t;

  typedef struct packed {
    logic               valid;
    logic [4:0]         rdindex;
    logic [SB_TAGW-1:0] itag;
  } wb_req_t;

endpackage

// File: rtl/scoreboard_ctrl_if.sv
// Scoreboard update bundle between dispatch (master) and the scoreboard
// (slave).
//   set_write   : dispatch set strobe
//   set_rdindex : destination register to mark busy
//   set_itag    : itag of the producing instruction
interface scoreboard_ctrl_if #(
  parameter int TAGW = scoreboard_ctrl_pkg::SB_TAGW
);
  logic            set_write;
  logic [4:0]      set_rdindex;
  logic [TAGW-1:0] set_itag;

  modport master (output set_write, output set_rdindex, output set_itag);
  modport slave  (input  set_write, input  set_rdindex, input  set_itag);
endinterface

// File: rtl/scoreboard_ctrl_popcount.sv
// sb_popcount32: combinational population count of a 32-bit vector.
//   vec_i : input vector
//   cnt_o : number of set bits, 0..32
module sb_popcount32 (
  input  logic [31:0] vec_i,
  output logic [5:0]  cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < 32; i++) begin
      cnt_o = cnt_o + 6'(vec_i[i]);
    end
  end

endmodule

// File: rtl/scoreboard_ctrl.sv
// scoreboard_ctrl: 32-entry integer-register scoreboard.
// Dispatch marks a destination busy and records its itag; writebacks clear
// the entry only when the returning itag matches; flush wipes all busy bits.
// Ports:
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   set_if         : dispatch set bundle (slave)
//   wb_valid_i/wb_rdindex_i/wb_itag_i : NWB packed writeback clear ports
//   flush_i        : pipeline flush
//   rd_index_i     : NRD packed lookup indices
//   rd_busy_o/rd_itag_o : per-lookup busy flag and recorded itag
//   busy_cnt_o     : number of busy entries (registered)
//   idle_o         : no entry busy
module scoreboard_ctrl
  import scoreboard_ctrl_pkg::*;
#(
  parameter int NWB  = 2,
  parameter int NRD  = 3,
  parameter int TAGW = SB_TAGW
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  scoreboard_ctrl_if.slave     set_if,
  input  logic [NWB-1:0]       wb_valid_i,
  input  logic [NWB*5-1:0]     wb_rdindex_i,
  input  logic [NWB*TAGW-1:0]  wb_itag_i,
  input  logic                 flush_i,
  input  logic [NRD*5-1:0]     rd_index_i,
  output logic [NRD-1:0]       rd_busy_o,
  output logic [NRD*TAGW-1:0]  rd_itag_o,
  output logic [5:0]           busy_cnt_o,
  output logic                 idle_o
);

  sb_entry_t [SB_NREGS-1:0] entry_q, entry_d;
  logic [5:0]               cnt_q, cnt_d;
  logic [SB_NREGS-1:0]      busy_nxt;
  wb_req_t                  wb_req [NWB];
  logic [4:0]               lk_idx [NRD];

  always_comb begin
    for (int p = 0; p < NWB; p++) begin
      wb_req[p].valid   = wb_valid_i[p];
      wb_req[p].rdindex = wb_rdindex_i[p*5 +: 5];
      wb_req[p].itag    = wb_itag_i[p*TAGW +: TAGW];
    end
  end

  // Priority is built up lowest-first so later assignments win:
  // clear, then set, then flush. Clears test the registered entry, so two
  // ports hitting the same entry simply clear it once.
  always_comb begin
    entry_d = entry_q;
    for (int p = 0; p < NWB; p++) begin
      if (wb_req[p].valid && entry_q[wb_req[p].rdindex].busy &&
          entry_q[wb_req[p].rdindex].itag == wb_req[p].itag) begin
        entry_d[wb_req[p].rdindex].busy = 1'b0;
      end
    end
    if (set_if.set_write && set_if.set_rdindex != 5'd0) begin
      entry_d[set_if.set_rdindex].busy = 1'b1;
      entry_d[set_if.set_rdindex].itag = set_if.set_itag;
    end
    if (flush_i) begin
      for (int i = 0; i < SB_NREGS; i++) begin
        entry_d[i].busy = 1'b0;
      end
    end
    // x0 is hardwired idle with a zero itag.
    entry_d[0] = '0;
  end

  always_comb begin
    for (int i = 0; i < SB_NREGS; i++) begin
      busy_nxt[i] = entry_d[i].busy;
    end
  end

  // Count the next-state busy vector so the registered count lines up with
  // the registered busy bits.
  sb_popcount32 u_popcount (
    .vec_i (busy_nxt),
    .cnt_o (cnt_d)
  );

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      entry_q <= '0;
      cnt_q   <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  // Lookups read registered state only; no bypass of same-cycle updates.
  always_comb begin
    rd_busy_o = '0;
    rd_itag_o = '0;
    for (int r = 0; r < NRD; r++) begin
      lk_idx[r] = rd_index_i[r*5 +: 5];
      if (lk_idx[r] != 5'd0) begin
        rd_busy_o[r]               = entry_q[lk_idx[r]].busy;
        rd_itag_o[r*TAGW +: TAGW]  = entry_q[lk_idx[r]].itag;
      end
    end
  end

  assign busy_cnt_o = cnt_q;
  assign idle_o     = (cnt_q == 6'd0);

endmodule
